// File: rtl/maxterm_pkg.sv
// -----------------------------------------------------------------------------
// maxterm_pkg
// Shared constants for the maxterm function block.
//   MAXTERM_MASK : truth table of F(a,b,c,d), bit n = F(n) with n = {a,b,c,d}.
//                  A 0 in bit n marks maxterm n of the product-of-sums form.
//   NUM_MAXTERMS : number of zero bits in MAXTERM_MASK (clauses in the product).
// -----------------------------------------------------------------------------
package maxterm_pkg;

    // F = PI M(2,3,5,7,10,11,13,15); read LSB-first this is 1,1,0,0,1,0,1,0,...
    localparam logic [15:0] MAXTERM_MASK = 16'b0101_0011_0101_0011;
    localparam int          NUM_MAXTERMS = 8;

    // True when index n is one of the maxterms (i.e. F(n) = 0).
    function automatic logic is_maxterm(input logic [3:0] n);
        return ~MAXTERM_MASK[n];
    endfunction

endpackage

// File: rtl/maxterm_clause.sv
// -----------------------------------------------------------------------------
// maxterm_clause
// One sum clause Mi of the product-of-sums form. Each literal is complemented
// when the matching bit of IDX is 1, so the clause is 0 only for n == IDX.
// Ports:
//   a, b, c, d : function variables, {a,b,c,d} = index n (a is the MSB)
//   sum        : clause value, 0 exactly when {a,b,c,d} == IDX
// -----------------------------------------------------------------------------
module maxterm_clause #(
    parameter logic [3:0] IDX = 4'd0
) (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic sum
);

    // XOR with a constant IDX bit selects the true or complemented literal.
    assign sum = (a ^ IDX[3]) | (b ^ IDX[2]) | (c ^ IDX[1]) | (d ^ IDX[0]);

endmodule

// File: rtl/maxterm.sv
// -----------------------------------------------------------------------------
// maxterm
// Four-input Boolean function F(a,b,c,d) = PI M(2,3,5,7,10,11,13,15)
// (equivalently (b + c')(b' + d')), built as an AND of maxterm clauses,
// with a combinational output and a registered copy.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset, clears func_max_q only
//   a, b, c, d : function variables, {a,b,c,d} = index n (a is the MSB)
//   func_max   : combinational F(a,b,c,d), independent of clk and rst
//   func_max_q : func_max registered on clk, 0 while rst is high
// -----------------------------------------------------------------------------
module maxterm
    import maxterm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic func_max,
    output logic func_max_q
);

    logic [15:0] clause_s;
    logic        func_max_d;

    // One clause per maxterm; non-maxterm slots are tied to 1 so they drop
    // out of the AND reduction.
    for (genvar i = 0; i < 16; i++) begin : g_clause
        if (is_maxterm(4'(i))) begin : g_max
            maxterm_clause #(
                .IDX (4'(i))
            ) u_clause (
                .a   (a),
                .b   (b),
                .c   (c),
                .d   (d),
                .sum (clause_s[i])
            );
        end else begin : g_pass
            assign clause_s[i] = 1'b1;
        end
    end

    assign func_max   = &clause_s;
    assign func_max_d = func_max;

    // Registered copy of the function, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            func_max_q <= 1'b0;
        end else begin
            func_max_q <= func_max_d;
        end
    end

endmodule

// File: tb/tb_maxterm.sv
// -----------------------------------------------------------------------------
// tb_maxterm
// Scoreboard bench for maxterm. Stimulus pushes expected values into queues;
// two monitors pop and compare: one for immediate checks (1 time unit after
// the push), one for the registered output after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_maxterm;

    typedef struct {
        string name;
        bit    sel_q;   // 0: check func_max, 1: check func_max_q
        bit    exp;
    } chk_t;

    logic clk;
    logic rst;
    logic a, b, c, d;
    logic func_max;
    logic func_max_q;

    int errors = 0;
    int checks = 0;

    chk_t now_q[$];   // immediate checks
    chk_t reg_q[$];   // func_max_q checks after the next rising edge

    // Hand-written truth table, bit n = F(n).
    logic [15:0] tt = 16'b0101_0011_0101_0011;

    maxterm dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .func_max   (func_max),
        .func_max_q (func_max_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_n(input logic [3:0] n);
        {a, b, c, d} = n;
    endtask

    task automatic push_now(input string name, input bit sel_q, input bit exp);
        chk_t e;
        e.name = name; e.sel_q = sel_q; e.exp = exp;
        now_q.push_back(e);
    endtask

    task automatic push_reg(input string name, input bit exp);
        chk_t e;
        e.name = name; e.sel_q = 1'b1; e.exp = exp;
        reg_q.push_back(e);
    endtask

    // Immediate-check monitor.
    initial begin
        chk_t e;
        logic act;
        forever begin
            wait (now_q.size() > 0);
            #1;
            e = now_q.pop_front();
            act = e.sel_q ? func_max_q : func_max;
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b (t=%0t)", e.name, act, e.exp, $time);
            end
        end
    end

    // Registered-output monitor: one expected value per rising edge.
    always @(posedge clk) begin
        chk_t e;
        #1;
        if (reg_q.size() > 0) begin
            e = reg_q.pop_front();
            checks++;
            if (func_max_q !== e.exp) begin
                errors++;
                $display("FAIL %s: func_max_q got %b expected %b (t=%0t)",
                         e.name, func_max_q, e.exp, $time);
            end
        end
    end

    // Directed sweep order and hand-computed results.
    logic [3:0] sweep_n [16] = '{4'd0, 4'd2, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                4'd8, 4'd10, 4'd9, 4'd11, 4'd12, 4'd15, 4'd13, 4'd14};
    bit         sweep_e [16] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                                1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    // Registered-path vectors after reset release, with expected F.
    logic [3:0] seq_n [6] = '{4'd2, 4'd0, 4'd5, 4'd6, 4'd13, 4'd9};
    bit         seq_e [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        logic bb, cc, dd, ref_f;
        rst = 1'b1;
        set_n(4'd0);
        #2;

        // Directed combinational sweep, 5 time units per code.
        for (int i = 0; i < 16; i++) begin
            set_n(sweep_n[i]);
            push_now($sformatf("sweep_n%0d", sweep_n[i]), 1'b0, sweep_e[i]);
            #5;
        end

        // Exhaustive: against the reduced formula and the truth table.
        for (int n = 0; n < 16; n++) begin
            set_n(4'(n));
            bb = n[2]; cc = n[1]; dd = n[0];
            ref_f = (bb | ~cc) & (~bb | ~dd);
            push_now($sformatf("formula_n%0d", n), 1'b0, ref_f);
            push_now($sformatf("table_n%0d", n), 1'b0, tt[n]);
            #5;
        end

        // Reset hold with n = 0 for three edges.
        set_n(4'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        push_now("rst_hold_q", 1'b1, 1'b0);
        push_now("rst_hold_f", 1'b0, 1'b1);
        #3;

        // Release reset; first capture of F(0) = 1 on the next edge.
        @(negedge clk);
        rst = 1'b0;
        push_reg("first_capture", 1'b1);

        // Latency: each code is captured one edge after it is applied.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_n(seq_n[i]);
            push_reg($sformatf("latency_n%0d", seq_n[i]), seq_e[i]);
        end

        // Make func_max_q = 1, then assert reset between edges.
        @(negedge clk);
        set_n(4'd0);
        push_reg("pre_async", 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        push_now("async_rst_q", 1'b1, 1'b0);
        push_now("async_rst_f", 1'b0, 1'b1);
        // Clock edges during reset must not load func_max_q.
        @(posedge clk);
        push_now("rst_ignores_clk", 1'b1, 1'b0);

        // Drain the scoreboards with a bounded wait.
        for (int t = 0; t < 200; t++) begin
            if (now_q.size() == 0 && reg_q.size() == 0) break;
            #1;
        end
        #3;
        if (now_q.size() != 0 || reg_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d/%0d entries left, expected 0",
                     now_q.size(), reg_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
